// File: rtl/kernel_sched_pkg.sv
// Shared types, default parameter values and the round-robin selector for
// the kernel job scheduler.
//   sched_state_t : dispatcher FSM state (IDLE, ISSUE)
//   rr_sel_t      : result of rr_select (one-hot grant, granted index, any_free)
//   rr_select()   : first non-busy kernel at or after rr_ptr, wrapping modulo
//                   kernel_num; kernels at index >= kernel_num are never granted
package kernel_sched_pkg;

    localparam int unsigned KERNEL_NUM_DEF = 8;
    localparam int unsigned ADDR_W_DEF     = 64;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 32;

    // Upper bound on KERNEL_NUM; selector vectors are sized to this.
    localparam int unsigned KMAX = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic            any_free;
        logic [3:0]      idx;
        logic [KMAX-1:0] grant;
    } rr_sel_t;

    function automatic rr_sel_t rr_select(
        input logic [3:0]      rr_ptr,
        input logic [KMAX-1:0] busy,
        input int unsigned     kernel_num
    );
        rr_sel_t     sel;
        int unsigned k;
        logic [3:0]  kk;
        sel = '0;
        for (int unsigned off = 0; off < KMAX; off++) begin
            if (off < kernel_num) begin
                k = 32'(rr_ptr) + off;
                if (k >= kernel_num) begin
                    k = k - kernel_num;
                end
                kk = k[3:0];
                if (!sel.any_free && !busy[kk]) begin
                    sel.any_free  = 1'b1;
                    sel.idx       = kk;
                    sel.grant[kk] = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/job_desc_fifo.sv
// Synchronous job descriptor FIFO with flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous empty (pointers to zero)
//   push       : write push_data when not full
//   pop        : advance read pointer when not empty; pop_data is the head
//   level      : occupancy 0..DEPTH
//   full/empty : status flags
module job_desc_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level    = wptr - rptr;
    assign full     = (level == FULL_LVL);
    assign empty    = (wptr == rptr);
    assign pop_data = mem[rptr[AW-1:0]];
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/kernel_job_scheduler.sv
// Round-robin dispatcher of job descriptors to KERNEL_NUM kernels.
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_enable           : allows new dispatches (FIFO accepts regardless)
//   i_clear            : synchronous soft clear (FIFO, counters, rr pointer, FSM)
//   i_job_valid/addr   : job push; o_job_ready = FIFO not full
//   o_kernel_start     : registered one-hot start pulse, o_kernel_addr with it
//   i_kernel_complete  : per-kernel done level, rising edge ends a job
//   o_kernel_busy      : per-kernel busy flags
//   o_fifo_level       : FIFO occupancy
//   o_idle             : FIFO empty, no kernel busy, FSM idle
//   o_dispatch_cnt     : jobs issued since reset/clear
//   o_complete_cnt     : completions counted since reset/clear
module kernel_job_scheduler
    import kernel_sched_pkg::*;
#(
    parameter int unsigned KERNEL_NUM = KERNEL_NUM_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_enable,
    input  logic                          i_clear,
    input  logic                          i_job_valid,
    output logic                          o_job_ready,
    input  logic [ADDR_W-1:0]             i_job_addr,
    output logic [KERNEL_NUM-1:0]         o_kernel_start,
    output logic [ADDR_W-1:0]             o_kernel_addr,
    input  logic [KERNEL_NUM-1:0]         i_kernel_complete,
    output logic [KERNEL_NUM-1:0]         o_kernel_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_idle,
    output logic [CNT_W-1:0]              o_dispatch_cnt,
    output logic [CNT_W-1:0]              o_complete_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       RR_LAST = 4'(KERNEL_NUM - 1);

    sched_state_t          state;
    sched_state_t          state_next;

    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_W-1:0]     fifo_head;

    logic [KERNEL_NUM-1:0] busy;
    logic [KERNEL_NUM-1:0] comp_q;
    logic [KERNEL_NUM-1:0] comp_prev;
    logic [KERNEL_NUM-1:0] done_mask;
    logic [CNT_W-1:0]      done_num;

    logic [KMAX-1:0]       busy_ext;
    rr_sel_t               sel;
    logic [KERNEL_NUM-1:0] grant;
    logic [3:0]            rr_ptr;
    logic [3:0]            rr_next;
    logic                  dispatch;
    logic                  unused_grant;

    logic [KERNEL_NUM-1:0] start_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [CNT_W-1:0]      disp_cnt;
    logic [CNT_W-1:0]      cmpl_cnt;

    // Clear wins over push in the same cycle.
    assign fifo_push   = i_job_valid & ~fifo_full & ~i_clear;
    assign o_job_ready = ~fifo_full;

    job_desc_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (i_clear),
        .push      (fifo_push),
        .push_data (i_job_addr),
        .pop       (dispatch),
        .pop_data  (fifo_head),
        .level     (o_fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Unimplemented selector lanes read as busy so they are never granted.
    always_comb begin
        busy_ext                 = '1;
        busy_ext[KERNEL_NUM-1:0] = busy;
    end

    assign sel          = rr_select(rr_ptr, busy_ext, KERNEL_NUM);
    assign grant        = sel.grant[KERNEL_NUM-1:0];
    assign unused_grant = |sel.grant;
    assign rr_next      = (sel.idx == RR_LAST) ? 4'd0 : sel.idx + 4'd1;

    // Done input is registered before edge detection, so a completion seen
    // at one edge acts on busy/count at the following edge.
    assign done_mask = comp_q & ~comp_prev & busy;

    always_comb begin
        done_num = '0;
        for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
            if (done_mask[i]) begin
                done_num = done_num + CNT_ONE;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (i_clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dispatch) state_next = ISSUE;
            ISSUE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        dispatch = 1'b0;
        if (state == IDLE && i_enable && !fifo_empty && sel.any_free && !i_clear) begin
            dispatch = 1'b1;
        end
    end

    // Busy flags and edge history survive a clear: kernels keep running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_q    <= '1;
            comp_prev <= '1;
            busy      <= '0;
            start_q   <= '0;
            addr_q    <= '0;
            rr_ptr    <= '0;
            disp_cnt  <= '0;
            cmpl_cnt  <= '0;
        end else begin
            comp_q    <= i_kernel_complete;
            comp_prev <= comp_q;
            busy      <= (busy & ~done_mask) | (dispatch ? grant : '0);
            if (i_clear) begin
                start_q  <= '0;
                rr_ptr   <= '0;
                disp_cnt <= '0;
                cmpl_cnt <= '0;
            end else begin
                start_q  <= dispatch ? grant : '0;
                cmpl_cnt <= cmpl_cnt + done_num;
                if (dispatch) begin
                    addr_q   <= fifo_head;
                    rr_ptr   <= rr_next;
                    disp_cnt <= disp_cnt + CNT_ONE;
                end
            end
        end
    end

    assign o_kernel_start = start_q;
    assign o_kernel_addr  = addr_q;
    assign o_kernel_busy  = busy;
    assign o_dispatch_cnt = disp_cnt;
    assign o_complete_cnt = cmpl_cnt;
    assign o_idle         = fifo_empty & ~(|busy) & (state == IDLE);

endmodule
